quantum_gate_pipe: RTL

Pipelined, parametrised single-qubit gate unit operating on complex amplitudes (separate real/imaginary lanes for α and β) in signed fixed point. It is the next-generation execution unit between the gate controller and the state register file: it accepts one (state, gate) transaction per cycle over a valid/ready handshake, applies I/H/X/Y/Z/S/T/S† with rounding and saturation, and returns the result two cycles later with per-transaction and sticky overflow flags.

---
 rtl/quantum_gate_pipe_pkg.sv | 23 ++
 rtl/quantum_gate_pipe_qg_scale_sat.sv | 42 ++++
 rtl/quantum_gate_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/quantum_gate_pipe_pkg.sv
// Shared definitions for the single-qubit gate pipeline: gate encodings
// common to the gate controller and the execution unit.
package quantum_gate_pipe_pkg;

  typedef enum logic [2:0] {
    GATE_I   = 3'b000,
    GATE_H   = 3'b001,
    GATE_X   = 3'b010,
    GATE_Z   = 3'b011,
    GATE_Y   = 3'b100,
    GATE_S   = 3'b101,
    GATE_T   = 3'b110,
    GATE_SDG = 3'b111
  } gate_e;

  // Lane order used for every 4-lane array in the pipeline.
  localparam int unsigned LANE_A_RE = 0;
  localparam int unsigned LANE_A_IM = 1;
  localparam int unsigned LANE_B_RE = 2;
  localparam int unsigned LANE_B_IM = 3;
  localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/quantum_gate_pipe_qg_scale_sat.sv
// One amplitude lane of the scale/saturate stage: optional multiply by a
// fixed-point constant with round-half-up, then clamp to the OUT_W signed range.
module qg_scale_sat #(
  parameter int IN_W   = 33,
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 16,
  parameter int K      = 46341
) (
  input  logic signed [IN_W-1:0]  lane_i,
  input  logic                    scale_i,
  output logic        [OUT_W-1:0] lane_o,
  output logic                    sat_o
);

  // K is positive; one extra bit keeps it positive as a signed operand, and
  // one more headroom bit absorbs the rounding add.
  localparam int K_W = $clog2(K + 1) + 1;
  localparam int W   = IN_W + K_W + 1;

  localparam logic signed [W-1:0] RND = {{(W-1){1'b0}}, 1'b1} << (FRAC_W - 1);

  logic signed [W-1:0] lane_ext;
  logic signed [W-1:0] k_ext;
  logic signed [W-1:0] prod;
  logic signed [W-1:0] rounded;
  logic signed [W-1:0] val;
  logic        [W-OUT_W:0] hi_bits;

  assign lane_ext = W'(lane_i);
  assign k_ext    = W'(K);
  assign prod     = lane_ext * k_ext;
  assign rounded  = (prod + RND) >>> FRAC_W;
  assign val      = scale_i ? rounded : lane_ext;

  // Value fits OUT_W only when all bits from the OUT_W sign bit upward agree.
  assign hi_bits = val[W-1:OUT_W-1];
  assign sat_o   = !((&hi_bits) || !(|hi_bits));
  assign lane_o  = sat_o ? (val[W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                     : {1'b0, {(OUT_W-1){1'b1}}})
                         : val[OUT_W-1:0];

endmodule

// File: rtl/quantum_gate_pipe.sv
// Two-stage single-qubit gate unit: stage 1 combines alpha/beta lanes exactly
// at DATA_W+1 bits, stage 2 scales by 1/sqrt(2) where needed and saturates.
module quantum_gate_pipe
  import quantum_gate_pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int FRAC_W    = 16,
  parameter int INV_SQRT2 = 46341,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_gate,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] in_a_re,
  input  logic [DATA_W-1:0] in_a_im,
  input  logic [DATA_W-1:0] in_b_re,
  input  logic [DATA_W-1:0] in_b_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_a_re,
  output logic [DATA_W-1:0] out_a_im,
  output logic [DATA_W-1:0] out_b_re,
  output logic [DATA_W-1:0] out_b_im,
  output logic              out_sat,
  output logic              sat_sticky,
  input  logic              sat_clear
);

  localparam int LW = DATA_W + 1;

  logic adv1;
  logic adv2;

  logic signed [LW-1:0] ar, ai, br, bi;

  logic signed [LW-1:0]     s1_lane_d  [NUM_LANES];
  logic        [NUM_LANES-1:0] s1_scale_d;
  logic signed [LW-1:0]     s1_lane_q  [NUM_LANES];
  logic        [NUM_LANES-1:0] s1_scale_q;
  logic        [TAG_W-1:0]  s1_tag_q;
  logic                     s1_valid_q;

  logic        [DATA_W-1:0] out_lane_d [NUM_LANES];
  logic        [NUM_LANES-1:0] lane_sat;
  logic        [DATA_W-1:0] out_lane_q [NUM_LANES];
  logic        [TAG_W-1:0]  out_tag_q;
  logic                     out_valid_q;
  logic                     out_sat_q;
  logic                     sat_sticky_q;
  logic                     sat_sticky_d;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  assign ar = {in_a_re[DATA_W-1], in_a_re};
  assign ai = {in_a_im[DATA_W-1], in_a_im};
  assign br = {in_b_re[DATA_W-1], in_b_re};
  assign bi = {in_b_im[DATA_W-1], in_b_im};

  // Stage 1: exact lane combination for the selected gate plus scale flags.
  always_comb begin
    s1_lane_d[LANE_A_RE] = ar;
    s1_lane_d[LANE_A_IM] = ai;
    s1_lane_d[LANE_B_RE] = br;
    s1_lane_d[LANE_B_IM] = bi;
    s1_scale_d           = '0;
    case (gate_e'(in_gate))
      GATE_H: begin
        s1_lane_d[LANE_A_RE] = ar + br;
        s1_lane_d[LANE_A_IM] = ai + bi;
        s1_lane_d[LANE_B_RE] = ar - br;
        s1_lane_d[LANE_B_IM] = ai - bi;
        s1_scale_d           = '1;
      end
      GATE_X: begin
        s1_lane_d[LANE_A_RE] = br;
        s1_lane_d[LANE_A_IM] = bi;
        s1_lane_d[LANE_B_RE] = ar;
        s1_lane_d[LANE_B_IM] = ai;
      end
      GATE_Z: begin
        s1_lane_d[LANE_B_RE] = -br;
        s1_lane_d[LANE_B_IM] = -bi;
      end
      GATE_Y: begin
        s1_lane_d[LANE_A_RE] = bi;
        s1_lane_d[LANE_A_IM] = -br;
        s1_lane_d[LANE_B_RE] = -ai;
        s1_lane_d[LANE_B_IM] = ar;
      end
      GATE_S: begin
        s1_lane_d[LANE_B_RE] = -bi;
        s1_lane_d[LANE_B_IM] = br;
      end
      GATE_T: begin
        s1_lane_d[LANE_B_RE] = br - bi;
        s1_lane_d[LANE_B_IM] = br + bi;
        s1_scale_d           = 4'b1100;
      end
      GATE_SDG: begin
        s1_lane_d[LANE_B_RE] = bi;
        s1_lane_d[LANE_B_IM] = -br;
      end
      default: begin
      end
    endcase
  end

  // Stage 1 register: loads on advance, holds everything while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_tag_q   <= '0;
      s1_scale_q <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) s1_lane_q[i] <= '0;
    end else if (adv1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_tag_q   <= in_tag;
        s1_scale_q <= s1_scale_d;
        for (int unsigned i = 0; i < NUM_LANES; i++) s1_lane_q[i] <= s1_lane_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    qg_scale_sat #(
      .IN_W   (LW),
      .OUT_W  (DATA_W),
      .FRAC_W (FRAC_W),
      .K      (INV_SQRT2)
    ) u_scale_sat (
      .lane_i  (s1_lane_q[g]),
      .scale_i (s1_scale_q[g]),
      .lane_o  (out_lane_d[g]),
      .sat_o   (lane_sat[g])
    );
  end

  // Stage 2 register: result, tag and per-transaction saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_sat_q   <= 1'b0;
      for (int unsigned i = 0; i < NUM_LANES; i++) out_lane_q[i] <= '0;
    end else if (adv2) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_tag_q <= s1_tag_q;
        out_sat_q <= |lane_sat;
        for (int unsigned i = 0; i < NUM_LANES; i++) out_lane_q[i] <= out_lane_d[i];
      end
    end
  end

  // Sticky saturation: a delivered saturating result takes priority over clear.
  always_comb begin
    sat_sticky_d = sat_sticky_q;
    if (out_valid_q && out_ready && out_sat_q) sat_sticky_d = 1'b1;
    else if (sat_clear)                        sat_sticky_d = 1'b0;
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_sticky_q <= 1'b0;
    else        sat_sticky_q <= sat_sticky_d;
  end

  assign out_valid  = out_valid_q;
  assign out_tag    = out_tag_q;
  assign out_sat    = out_sat_q;
  assign sat_sticky = sat_sticky_q;
  assign out_a_re   = out_lane_q[LANE_A_RE];
  assign out_a_im   = out_lane_q[LANE_A_IM];
  assign out_b_re   = out_lane_q[LANE_B_RE];
  assign out_b_im   = out_lane_q[LANE_B_IM];

endmodule
